// File: rtl/digit_locator_if.sv
// ============================================================================
// Module      : digit_locator_if
// Description : Scan, pixel-sample and result/handshake bundle for the
//               digit locator. Optional macro: DIGIT_LOCATOR_DELTA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface digit_locator_if;
    logic        scan_en;
    logic [6:0]  px;
    logic [6:0]  py;
    logic [15:0] pixel_data;
    logic [6:0]  box_x;
    logic [6:0]  box_y;
    logic [6:0]  box_w;
    logic [6:0]  box_h;
    logic [12:0] pixel_count;
    logic        found;
    logic        frame_done;
    logic        result_valid;
    logic        result_ack;
    logic        overrun;
`ifdef DIGIT_LOCATOR_DELTA_EN
    logic signed [7:0] delta_x;
    logic              moving_right;

    modport master (
        input  scan_en, pixel_data, result_ack,
        output px, py, box_x, box_y, box_w, box_h, pixel_count,
               found, frame_done, result_valid, overrun,
               delta_x, moving_right
    );
    modport slave (
        output scan_en, pixel_data, result_ack,
        input  px, py, box_x, box_y, box_w, box_h, pixel_count,
               found, frame_done, result_valid, overrun,
               delta_x, moving_right
    );
`else
    modport master (
        input  scan_en, pixel_data, result_ack,
        output px, py, box_x, box_y, box_w, box_h, pixel_count,
               found, frame_done, result_valid, overrun
    );
    modport slave (
        output scan_en, pixel_data, result_ack,
        input  px, py, box_x, box_y, box_w, box_h, pixel_count,
               found, frame_done, result_valid, overrun
    );
`endif
endinterface

`default_nettype wire

// File: rtl/digit_locator.sv
// ============================================================================
// Module      : digit_locator
// Description : Raster-scans the OLED space and recovers bounding box and
//               pixel count of TARGET_COLOUR pixels. Optional macro:
//               DIGIT_LOCATOR_DELTA_EN (frame-to-frame horizontal motion).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module digit_locator #(
    parameter int          OLED_WIDTH    = 96,
    parameter int          OLED_HEIGHT   = 64,
    parameter logic [15:0] TARGET_COLOUR = 16'hAEDC
) (
    input  logic            clk,
    input  logic            reset,
    digit_locator_if.master bus
);

    localparam logic [6:0] c_LAST_X = 7'(OLED_WIDTH - 1);
    localparam logic [6:0] c_LAST_Y = 7'(OLED_HEIGHT - 1);

    logic [6:0]  r_px, r_py;
    logic [6:0]  r_min_x, r_max_x, r_min_y, r_max_y;
    logic [12:0] r_count;
    logic [6:0]  r_box_x, r_box_y, r_box_w, r_box_h;
    logic [12:0] r_pixel_count;
    logic        r_found, r_frame_done, r_result_valid, r_overrun;

    logic        w_step, w_match, w_frame_end, w_found;
    logic [6:0]  w_min_x, w_max_x, w_min_y, w_max_y;
    logic [12:0] w_count;

    // Accumulator values including the pixel sampled this cycle, so the
    // frame-end step can publish the last pixel without an extra cycle.
    assign w_step      = bus.scan_en;
    assign w_match     = w_step && (bus.pixel_data == TARGET_COLOUR);
    assign w_frame_end = w_step && (r_px == c_LAST_X) && (r_py == c_LAST_Y);
    assign w_min_x     = (w_match && (r_px < r_min_x)) ? r_px : r_min_x;
    assign w_max_x     = (w_match && (r_px > r_max_x)) ? r_px : r_max_x;
    assign w_min_y     = (w_match && (r_py < r_min_y)) ? r_py : r_min_y;
    assign w_max_y     = (w_match && (r_py > r_max_y)) ? r_py : r_max_y;
    assign w_count     = r_count + {12'd0, w_match};
    assign w_found     = (w_count != 13'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_px           <= 7'd0;
            r_py           <= 7'd0;
            r_min_x        <= 7'd127;
            r_min_y        <= 7'd127;
            r_max_x        <= 7'd0;
            r_max_y        <= 7'd0;
            r_count        <= 13'd0;
            r_box_x        <= 7'd0;
            r_box_y        <= 7'd0;
            r_box_w        <= 7'd0;
            r_box_h        <= 7'd0;
            r_pixel_count  <= 13'd0;
            r_found        <= 1'b0;
            r_frame_done   <= 1'b0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (bus.result_ack) begin
                r_result_valid <= 1'b0;
            end
            if (w_step) begin
                if (r_px == c_LAST_X) begin
                    r_px <= 7'd0;
                    r_py <= (r_py == c_LAST_Y) ? 7'd0 : r_py + 7'd1;
                end else begin
                    r_px <= r_px + 7'd1;
                end

                if (w_frame_end) begin
                    r_min_x        <= 7'd127;
                    r_min_y        <= 7'd127;
                    r_max_x        <= 7'd0;
                    r_max_y        <= 7'd0;
                    r_count        <= 13'd0;
                    r_box_x        <= w_found ? w_min_x : 7'd0;
                    r_box_y        <= w_found ? w_min_y : 7'd0;
                    r_box_w        <= w_found ? (w_max_x - w_min_x + 7'd1) : 7'd0;
                    r_box_h        <= w_found ? (w_max_y - w_min_y + 7'd1) : 7'd0;
                    r_pixel_count  <= w_count;
                    r_found        <= w_found;
                    r_frame_done   <= 1'b1;
                    r_result_valid <= 1'b1;
                    if (r_result_valid && !bus.result_ack) begin
                        r_overrun <= 1'b1;
                    end
                end else begin
                    r_min_x <= w_min_x;
                    r_min_y <= w_min_y;
                    r_max_x <= w_max_x;
                    r_max_y <= w_max_y;
                    r_count <= w_count;
                end
            end
        end
    end

    assign bus.px           = r_px;
    assign bus.py           = r_py;
    assign bus.box_x        = r_box_x;
    assign bus.box_y        = r_box_y;
    assign bus.box_w        = r_box_w;
    assign bus.box_h        = r_box_h;
    assign bus.pixel_count  = r_pixel_count;
    assign bus.found        = r_found;
    assign bus.frame_done   = r_frame_done;
    assign bus.result_valid = r_result_valid;
    assign bus.overrun      = r_overrun;

`ifdef DIGIT_LOCATOR_DELTA_EN
    logic [6:0]        r_prev_x;
    logic              r_prev_found;
    logic signed [7:0] r_delta_x;
    logic              r_moving_right;
    logic [7:0]        w_delta_raw;
    logic              w_both_found;

    assign w_delta_raw  = {1'b0, w_min_x} - {1'b0, r_prev_x};
    assign w_both_found = w_found && r_prev_found;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_x       <= 7'd0;
            r_prev_found   <= 1'b0;
            r_delta_x      <= 8'sd0;
            r_moving_right <= 1'b0;
        end else if (w_frame_end) begin
            r_prev_x       <= w_found ? w_min_x : 7'd0;
            r_prev_found   <= w_found;
            r_delta_x      <= w_both_found ? $signed(w_delta_raw) : 8'sd0;
            r_moving_right <= w_both_found && (w_min_x > r_prev_x);
        end
    end

    assign bus.delta_x      = r_delta_x;
    assign bus.moving_right = r_moving_right;
`endif

endmodule

`default_nettype wire
